// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU/forwarding encodings and the
// ID/EX control bundle with its bubble value.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7_5;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // An invalid ID slot still carries its fields, but must never cause side effects.
  function automatic ctrl_t mask_enables(input ctrl_t c);
    ctrl_t m;
    m            = c;
    m.reg_write  = 1'b0;
    m.mem_read   = 1'b0;
    m.mem_write  = 1'b0;
    m.mem_to_reg = 1'b0;
    m.branch     = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose rd feeds the instruction in ID.
module id_ex_hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              load_use_hazard
);

  assign load_use_hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                           ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush bubble and load-use bubble insertion.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int XLEN   = cpu_pkg::XLEN,
`ifdef ID_EX_PERF_CNT_EN
  parameter int PERF_W = 32,
`endif
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_Read_data_1,
  input  logic [XLEN-1:0]   id_Read_data_2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_ALU_Src,
  input  logic [1:0]        id_ALUOp,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic              id_Branch,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_Read_data_1,
  output logic [XLEN-1:0]   ex_Read_data_2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_ALU_Src,
  output logic [1:0]        ex_ALUOp,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7_5,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_MemtoReg,
  output logic              ex_Branch,
`ifdef ID_EX_PERF_CNT_EN
  output logic [PERF_W-1:0] bubble_cnt,
`endif
  output logic              load_use_hazard
);

  import cpu_pkg::*;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  ctrl_t             ctrl_q, ctrl_d, id_ctrl;
  logic              load_bubble;

  assign id_ctrl = '{reg_write: id_RegWrite, mem_read: id_MemRead, mem_write: id_MemWrite,
                     mem_to_reg: id_MemtoReg, branch: id_Branch, alu_src: id_ALU_Src,
                     alu_op: id_ALUOp, funct3: id_funct3, funct7_5: id_funct7_5};

  id_ex_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid        (valid_q),
    .ex_mem_read     (ctrl_q.mem_read),
    .ex_rd           (rd_q),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .load_use_hazard (load_use_hazard)
  );

  // Flush beats stall so a squashed instruction cannot survive a frozen pipeline.
  assign load_bubble = flush | (~stall & load_use_hazard);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      pc_d    = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (!stall) begin
      valid_d = id_valid;
      pc_d    = id_pc;
      rd1_d   = id_Read_data_1;
      rd2_d   = id_Read_data_2;
      imm_d   = id_imm;
      rs1_d   = id_rs1;
      rs2_d   = id_rs2;
      rd_d    = id_rd;
      ctrl_d  = id_valid ? id_ctrl : mask_enables(id_ctrl);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble) bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign ex_valid       = valid_q;
  assign ex_pc          = pc_q;
  assign ex_Read_data_1 = rd1_q;
  assign ex_Read_data_2 = rd2_q;
  assign ex_imm         = imm_q;
  assign ex_rs1         = rs1_q;
  assign ex_rs2         = rs2_q;
  assign ex_rd          = rd_q;
  assign ex_ALU_Src     = ctrl_q.alu_src;
  assign ex_ALUOp       = ctrl_q.alu_op;
  assign ex_funct3      = ctrl_q.funct3;
  assign ex_funct7_5    = ctrl_q.funct7_5;
  assign ex_RegWrite    = ctrl_q.reg_write;
  assign ex_MemRead     = ctrl_q.mem_read;
  assign ex_MemWrite    = ctrl_q.mem_write;
  assign ex_MemtoReg    = ctrl_q.mem_to_reg;
  assign ex_Branch      = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios then random traffic against a stage model.
// Counter checks are compiled in when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_src;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7;
    logic        rw, mr, mw, m2r, br;
  } stage_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   stall = 1'b0, flush = 1'b0;
  stage_t id_s = '0;
  stage_t obs;
  stage_t m_ex;
  logic   haz;
  int     m_cnt = 0;
  int     n_checks = 0, n_fail = 0;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_s.valid), .id_pc(id_s.pc), .id_Read_data_1(id_s.rd1),
    .id_Read_data_2(id_s.rd2), .id_imm(id_s.imm), .id_rs1(id_s.rs1), .id_rs2(id_s.rs2),
    .id_rd(id_s.rd), .id_ALU_Src(id_s.alu_src), .id_ALUOp(id_s.aluop),
    .id_funct3(id_s.f3), .id_funct7_5(id_s.f7), .id_RegWrite(id_s.rw),
    .id_MemRead(id_s.mr), .id_MemWrite(id_s.mw), .id_MemtoReg(id_s.m2r),
    .id_Branch(id_s.br),
    .ex_valid(obs.valid), .ex_pc(obs.pc), .ex_Read_data_1(obs.rd1),
    .ex_Read_data_2(obs.rd2), .ex_imm(obs.imm), .ex_rs1(obs.rs1), .ex_rs2(obs.rs2),
    .ex_rd(obs.rd), .ex_ALU_Src(obs.alu_src), .ex_ALUOp(obs.aluop),
    .ex_funct3(obs.f3), .ex_funct7_5(obs.f7), .ex_RegWrite(obs.rw),
    .ex_MemRead(obs.mr), .ex_MemWrite(obs.mw), .ex_MemtoReg(obs.m2r),
    .ex_Branch(obs.br),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .load_use_hazard(haz)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hazard rule: a valid load in EX writing a nonzero register read by a valid ID instruction.
  function automatic logic model_hazard(input stage_t ex, input stage_t id);
    return id.valid && ex.valid && ex.mr && ex.rd != 0 && (ex.rd == id.rs1 || ex.rd == id.rs2);
  endfunction

  task automatic check_cnt(input string tag);
`ifdef ID_EX_PERF_CNT_EN
    check(tag, 160'(bubble_cnt), 160'(m_cnt));
`endif
  endtask

  // One cycle: drive ID, check hazard, clock, update model, check EX bundle.
  task automatic step(input stage_t id, input logic st, input logic fl);
    logic h;
    id_s = id; stall = st; flush = fl;
    #1;
    h = model_hazard(m_ex, id);
    check("hazard", 160'(haz), 160'(h));
    @(posedge clk);
    if (fl) begin
      m_ex = '0; m_cnt++;
    end else if (st) begin
      m_ex = m_ex;
    end else if (h) begin
      m_ex = '0; m_cnt++;
    end else begin
      m_ex = id;
      if (!id.valid) begin
        m_ex.rw = 0; m_ex.mr = 0; m_ex.mw = 0; m_ex.m2r = 0; m_ex.br = 0;
      end
    end
    #1;
    $display("cycle t=%0t valid=%b st=%b fl=%b haz=%b ex_rd=%0d ex_valid=%b",
             $time, id.valid, st, fl, haz, obs.rd, obs.valid);
    check("ex_bundle", 160'(obs), 160'(m_ex));
    check_cnt("bubble_cnt");
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    m_ex = '0; m_cnt = 0;
    check("reset_async", 160'(obs), 160'(0));
    check_cnt("reset_cnt");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic stage_t rand_id();
    stage_t s;
    s = stage_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    s.valid = ($urandom_range(0, 3) != 0);
    s.rs1 = 5'($urandom_range(0, 7));
    s.rs2 = 5'($urandom_range(0, 7));
    s.rd  = 5'($urandom_range(0, 7));
    s.mr  = ($urandom_range(0, 1) == 1);
    return s;
  endfunction

  function automatic stage_t instr(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic load);
    stage_t s;
    s = '0;
    s.valid = 1; s.pc = 32'h100 + 32'(rd); s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.rw = 1; s.mr = load; s.m2r = load; s.alu_src = load;
    return s;
  endfunction

  initial begin
    stage_t t;
    stage_t held;
    m_ex = '0;
    #1;
    check("reset_state", 160'(obs), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // capture of sign-extended immediate with ALU_Src
    t = instr(5'd5, 5'd1, 5'd2, 1'b0);
    t.imm = 32'hFFFF_FFF0; t.alu_src = 1;
    step(t, 0, 0);
    check("cap_rd", 160'(obs.rd), 160'(5));
    check("cap_imm", 160'(obs.imm), 160'(32'hFFFF_FFF0));
    check("cap_alusrc", 160'(obs.alu_src), 160'(1));
    check("cap_rw", 160'(obs.rw), 160'(1));

    // asynchronous reset while a RegWrite instruction sits in EX
    do_reset();

    // load-use: lw x6 then add x7,x6,x2
    step(instr(5'd6, 5'd1, 5'd0, 1'b1), 0, 0);
    id_s = instr(5'd7, 5'd6, 5'd2, 1'b0);
    #1 check("lu_haz_hi", 160'(haz), 160'(1));
    step(instr(5'd7, 5'd6, 5'd2, 1'b0), 0, 0);
    check("lu_bubble", 160'(obs.valid), 160'(0));
    check("lu_bubble_rd", 160'(obs.rd), 160'(0));
    step(instr(5'd7, 5'd6, 5'd2, 1'b0), 0, 0);
    check("lu_capture_rd", 160'(obs.rd), 160'(7));

    // lw x0 never raises a hazard
    step(instr(5'd0, 5'd1, 5'd1, 1'b1), 0, 0);
    id_s = instr(5'd8, 5'd0, 5'd0, 1'b0);
    #1 check("x0_no_haz", 160'(haz), 160'(0));
    step(instr(5'd8, 5'd0, 5'd0, 1'b0), 0, 0);
    check("x0_capture", 160'(obs.rd), 160'(8));

    // stall alone holds, flush+stall bubbles
    held = obs;
    step(rand_id(), 1, 0);
    check("stall_hold", 160'(obs), 160'(held));
    step(rand_id(), 1, 1);
    check("flush_stall", 160'(obs), 160'(0));

    // invalid ID slot: fields copied, enables forced low
    t = instr(5'd9, 5'd3, 5'd4, 1'b1); t.valid = 0; t.mw = 1; t.br = 1;
    step(t, 0, 0);
    check("inv_rd", 160'(obs.rd), 160'(9));
    check("inv_en", 160'({obs.rw, obs.mr, obs.mw, obs.m2r, obs.br}), 160'(0));

    // 3 hazards + 2 flushes + 4 stalls
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(instr(5'd6, 5'd1, 5'd0, 1'b1), 0, 0);
      step(instr(5'd7, 5'd6, 5'd2, 1'b0), 0, 0);
    end
    for (int i = 0; i < 2; i++) step(instr(5'd3, 5'd1, 5'd2, 1'b0), 0, 1);
    for (int i = 0; i < 4; i++) step(rand_id(), 1, 0);
`ifdef ID_EX_PERF_CNT_EN
    check("cnt_five", 160'(bubble_cnt), 160'(5));
`endif

    // random traffic
    for (int i = 0; i < 300; i++)
      step(rand_id(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
